// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector: freezes PC and IF/ID and bubbles ID/EX on load-use,
// branch-operand and HI/LO (multi-cycle mult/div) hazards; counts stalled cycles.
module hazard_stall_unit #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       IDRs,
    input  logic [4:0]       IDRt,
    input  logic             IDUsesRs,
    input  logic             IDUsesRt,
    input  logic             IDBranch,
    input  logic             IDMultDiv,
    input  logic             IDReadH,
    input  logic             IDReadL,
    input  logic             EXMemRead,
    input  logic             EXRegWrite,
    input  logic [4:0]       EXWriteReg,
    input  logic             MEMMemRead,
    input  logic [4:0]       MEMWriteReg,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             MDBusy,
    output logic [CNT_W-1:0] StallCycles
);

    // Keep the counter at least one bit wide so MD_LATENCY = 0 still elaborates;
    // in that case it only ever loads zero and MDBusy stays low.
    localparam int MD_W = (MD_LATENCY > 0) ? $clog2(MD_LATENCY + 1) : 1;
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LATENCY);

    logic [MD_W-1:0] md_cnt;
    logic            md_busy;
    logic            load_use_stall;
    logic            branch_ex_stall;
    logic            branch_mem_stall;
    logic            hilo_stall;
    logic            stall;
    logic            md_accept;

    function automatic logic match_x(input logic [4:0] r,
                                     input logic [4:0] rs, input logic use_rs,
                                     input logic [4:0] rt, input logic use_rt);
        return (r != 5'd0) && (((r == rs) && use_rs) || ((r == rt) && use_rt));
    endfunction

    assign md_busy = (md_cnt != '0);

    always_comb begin
        load_use_stall   = EXMemRead &&
                           match_x(EXWriteReg, IDRs, IDUsesRs, IDRt, IDUsesRt);
        branch_ex_stall  = IDBranch && EXRegWrite &&
                           match_x(EXWriteReg, IDRs, IDUsesRs, IDRt, IDUsesRt);
        branch_mem_stall = IDBranch && MEMMemRead &&
                           match_x(MEMWriteReg, IDRs, IDUsesRs, IDRt, IDUsesRt);
        hilo_stall       = md_busy && (IDReadH || IDReadL || IDMultDiv);
        stall            = load_use_stall || branch_ex_stall ||
                           branch_mem_stall || hilo_stall;
        md_accept        = IDMultDiv && !stall;
    end

    // Reset overrides the hazard logic so the front end keeps flowing while Rst is high.
    always_comb begin
        PCWrite   = Rst || !stall;
        IFIDWrite = Rst || !stall;
        IDEXWrite = Rst || !stall;
        MDBusy    = !Rst && md_busy;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; reset here is synchronous because Rst is only seen at the edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            md_cnt      <= '0;
            StallCycles <= '0;
        end else begin
            if (md_accept)
                md_cnt <= MD_LOAD;
            else if (md_busy)
                md_cnt <= md_cnt - 1'b1;

            if (stall && (StallCycles != {CNT_W{1'b1}}))
                StallCycles <= StallCycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_stall_unit;

    localparam int MD_LATENCY = 4;
    localparam int CNT_W      = 4;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [4:0]       IDRs, IDRt, EXWriteReg, MEMWriteReg;
    logic             IDUsesRs, IDUsesRt, IDBranch, IDMultDiv, IDReadH, IDReadL;
    logic             EXMemRead, EXRegWrite, MEMMemRead;
    logic             PCWrite, IFIDWrite, IDEXWrite, MDBusy;
    logic [CNT_W-1:0] StallCycles;

    typedef struct {
        string      name;
        logic [7:0] exp;   // {PCWrite, IFIDWrite, IDEXWrite, MDBusy, StallCycles}
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    hazard_stall_unit #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst),
        .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
        .IDBranch(IDBranch), .IDMultDiv(IDMultDiv), .IDReadH(IDReadH), .IDReadL(IDReadL),
        .EXMemRead(EXMemRead), .EXRegWrite(EXRegWrite), .EXWriteReg(EXWriteReg),
        .MEMMemRead(MEMMemRead), .MEMWriteReg(MEMWriteReg),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
        .MDBusy(MDBusy), .StallCycles(StallCycles)
    );

    always #5 Clk = ~Clk;

    task automatic clr();
        Rst = 1'b0; IDRs = '0; IDRt = '0; IDUsesRs = 0; IDUsesRt = 0;
        IDBranch = 0; IDMultDiv = 0; IDReadH = 0; IDReadL = 0;
        EXMemRead = 0; EXRegWrite = 0; EXWriteReg = '0;
        MEMMemRead = 0; MEMWriteReg = '0;
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic step();
        @(posedge Clk);
        #1;
        clr();
    endtask

    task automatic push(input string n, input logic stall, input logic busy, input int sc);
        exp_t e;
        e.name = n;
        e.exp  = {~stall, ~stall, ~stall, busy, 4'(sc)};
        q.push_back(e);
    endtask

    task automatic load_use8();
        EXMemRead = 1; EXWriteReg = 5'd8; IDRs = 5'd8; IDUsesRs = 1;
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [7:0] act;
            e   = q.pop_front();
            act = {PCWrite, IFIDWrite, IDEXWrite, MDBusy, StallCycles};
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got {pc,ifid,idex,busy,cnt}=%b required %b",
                         e.name, act, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);

        // Reset still asserted with a live hazard: outputs forced open.
        step(); Rst = 1; load_use8();                           push("rst_forced", 0, 0, 0);

        step(); load_use8();                                    push("load_use", 1, 0, 0);
        step();                                                 push("after_load", 0, 0, 1);
        step(); EXMemRead = 1; IDUsesRs = 1;                    push("reg0", 0, 0, 1);
        step(); EXMemRead = 1; EXWriteReg = 9; IDRt = 9;        push("rt_unused", 0, 0, 1);
        step(); EXMemRead = 1; EXWriteReg = 9; IDRt = 9; IDUsesRt = 1;
                                                                push("load_use_rt", 1, 0, 1);

        step(); IDBranch = 1; IDRt = 5; IDUsesRt = 1; EXRegWrite = 1; EXWriteReg = 5;
                                                                push("branch_ex", 1, 0, 2);
        step(); IDBranch = 1; IDRt = 5; IDUsesRt = 1; MEMMemRead = 1; MEMWriteReg = 5;
                                                                push("branch_mem", 1, 0, 3);
        step(); IDBranch = 1; IDRt = 5; IDUsesRt = 1;           push("branch_clear", 0, 0, 4);
        step(); IDRt = 5; IDUsesRt = 1; EXRegWrite = 1; EXWriteReg = 5;
                                                                push("ex_wr_nobranch", 0, 0, 4);
        step(); IDRt = 5; IDUsesRt = 1; MEMMemRead = 1; MEMWriteReg = 5;
                                                                push("mem_ld_nobranch", 0, 0, 4);

        // mult accepted, then mfhi waits exactly MD_LATENCY cycles.
        step(); IDMultDiv = 1;                                  push("mult_accept", 0, 0, 4);
        for (int i = 0; i < 4; i++) begin
            step(); IDReadH = 1;                                push("mfhi_wait", 1, 1, 4 + i);
        end
        step(); IDReadH = 1;                                    push("mfhi_go", 0, 0, 8);

        // Back-to-back mult/div, then mflo; count saturates at 15.
        step(); IDMultDiv = 1;                                  push("mult1", 0, 0, 8);
        for (int i = 0; i < 4; i++) begin
            step(); IDMultDiv = 1;                              push("mult2_wait", 1, 1, 8 + i);
        end
        step(); IDMultDiv = 1;                                  push("mult2_go", 0, 0, 12);
        step(); IDReadL = 1;                                    push("mflo_wait", 1, 1, 12);
        step(); IDReadL = 1;                                    push("mflo_wait", 1, 1, 13);
        step(); IDReadL = 1;                                    push("mflo_wait", 1, 1, 14);
        step(); IDReadL = 1;                                    push("mflo_wait_sat", 1, 1, 15);
        step(); IDReadL = 1;                                    push("mflo_go_sat", 0, 0, 15);

        // Reset while a mult/div is pending.
        step(); IDMultDiv = 1;                                  push("mult_pre_rst", 0, 0, 15);
        step();                                                 push("busy_1", 0, 1, 15);
        step();                                                 push("busy_2", 0, 1, 15);
        step(); Rst = 1; IDReadH = 1;                           push("rst_mid_busy", 0, 0, 15);
        step(); IDReadH = 1;                                    push("mfhi_after_rst", 0, 0, 0);

        // Load-use and HI/LO together count once.
        step(); IDMultDiv = 1;                                  push("mult_combo", 0, 0, 0);
        step(); IDReadH = 1; load_use8();                       push("combined", 1, 1, 0);
        step();                                                 push("combined_after", 0, 1, 1);

        // Held load-use for 20 cycles; md_cnt keeps draining (2, 1, then 0).
        for (int i = 0; i < 20; i++) begin
            step(); load_use8();
            push("sat_hold", 1, (i < 2), (1 + i > 15) ? 15 : 1 + i);
        end
        step();                                                 push("sat_release", 0, 0, 15);

        step();
        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge Clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors never checked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
